// File: rtl/inst_ram_responder_if.sv
// Fetch channel between the instruction cache (master) and the RAM responder (slave).
// InstRead is a level request held until the one-cycle InstReady pulse is seen.
interface inst_ram_responder_if;
   logic        InstRead;
   logic [31:0] InstAddress;
   logic        InstReady;
   logic [31:0] InstfromRam;
   logic        AddrErr;

   modport master (
      output InstRead,
      output InstAddress,
      input  InstReady,
      input  InstfromRam,
      input  AddrErr
   );

   modport slave (
      input  InstRead,
      input  InstAddress,
      output InstReady,
      output InstfromRam,
      output AddrErr
   );
endinterface

// File: rtl/inst_ram_responder.sv
// Instruction RAM behind the I-cache refill port: InstReady pulses LATENCY edges after accept.
// One request at a time; a request still held after its response is parked in HOLD until released.
module inst_ram_responder #(
   parameter int          ADDR_W   = 14,
   parameter int          LATENCY  = 4,
   parameter logic [31:0] OOR_DATA = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 nReset,
   inst_ram_responder_if.slave  fetch,
   input  logic                 LoadEn,
   input  logic [31:0]          LoadAddr,
   input  logic [31:0]          LoadData,
   output logic                 Busy
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [31:0] mem [0:(2**ADDR_W)-1];

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              oor_q, oor_d;
   logic              mis_q, mis_d;
   logic [31:0]       data_q, data_d;

   logic load_in_range;
   logic unused_load_lsbs;

   assign load_in_range    = ~|LoadAddr[31:ADDR_W+2];
   assign unused_load_lsbs = &{1'b0, LoadAddr[1:0]};

   // Preload port; memory is not reset so the program image survives nReset.
   always_ff @(posedge clk) begin
      if (LoadEn && load_in_range) begin
         mem[LoadAddr[ADDR_W+1:2]] <= LoadData;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      oor_d   = oor_q;
      mis_d   = mis_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (fetch.InstRead) begin
               idx_d   = fetch.InstAddress[ADDR_W+1:2];
               oor_d   = |fetch.InstAddress[31:ADDR_W+2];
               mis_d   = |fetch.InstAddress[1:0];
               cnt_d   = CNT_INIT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A dropped request is a flush/branch abort: no response is owed.
            if (!fetch.InstRead) begin
               state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               data_d  = oor_q ? OOR_DATA : mem[idx_q];
               state_d = RESP;
            end
         end
         RESP: state_d = HOLD;
         HOLD: begin
            if (!fetch.InstRead) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         oor_q   <= 1'b0;
         mis_q   <= 1'b0;
         data_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         oor_q   <= oor_d;
         mis_q   <= mis_d;
         data_q  <= data_d;
      end
   end

   assign fetch.InstReady   = (state_q == RESP);
   assign fetch.AddrErr     = (state_q == RESP) && (oor_q || mis_q);
   assign fetch.InstfromRam = data_q;
   assign Busy              = (state_q != IDLE);
endmodule

// File: tb/tb_inst_ram_responder.sv
// Directed and randomized bench for inst_ram_responder at LATENCY=4 and LATENCY=1.
// Expected words come from an associative-array memory image updated by the preload rules.
module tb_inst_ram_responder;
   localparam int AW = 14;

   logic        clk = 1'b0;
   logic        nReset = 1'b0;
   logic        LoadEn = 1'b0;
   logic [31:0] LoadAddr = 32'd0;
   logic [31:0] LoadData = 32'd0;
   logic        busy4, busy1;

   inst_ram_responder_if f4 ();
   inst_ram_responder_if f1 ();

   inst_ram_responder #(.ADDR_W(AW), .LATENCY(4), .OOR_DATA(32'h0000_0013)) dut4 (
      .clk(clk), .nReset(nReset), .fetch(f4),
      .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .Busy(busy4)
   );

   inst_ram_responder #(.ADDR_W(AW), .LATENCY(1), .OOR_DATA(32'h0000_0013)) dut1 (
      .clk(clk), .nReset(nReset), .fetch(f1),
      .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .Busy(busy1)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [31:0] ref_mem [int];
   int loaded_idx [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit in_range(input logic [31:0] a);
      return (a >> (AW + 2)) == 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      LoadEn = 1'b1; LoadAddr = a; LoadData = d;
      tick();
      LoadEn = 1'b0;
      if (in_range(a)) begin
         ref_mem[int'(a[AW+1:2])] = d;
         loaded_idx.push_back(int'(a[AW+1:2]));
      end
   endtask

   // One full request: accept, wait LATENCY edges, check the pulse, hold, release.
   task automatic req(input string tag, input bit use1, input logic [31:0] a, input int hold,
                      input bit ld, input int ld_edge, input logic [31:0] ld_a, input logic [31:0] ld_d);
      int lat;
      int early;
      int extra;
      logic [31:0] exp_d;
      logic        exp_e;
      int idx;
      lat   = use1 ? 1 : 4;
      early = 0;
      extra = 0;
      idx   = int'(a[AW+1:2]);
      exp_e = !in_range(a) || (a[1:0] != 2'b00);
      if (!in_range(a))
         exp_d = 32'h0000_0013;
      else if (ld && ld_edge < lat && in_range(ld_a) && int'(ld_a[AW+1:2]) == idx)
         exp_d = ld_d;
      else
         exp_d = ref_mem.exists(idx) ? ref_mem[idx] : 32'hxxxx_xxxx;

      f4.InstAddress = a; f1.InstAddress = a;
      if (use1) f1.InstRead = 1'b1; else f4.InstRead = 1'b1;
      for (int e = 0; e <= lat; e++) begin
         if (ld && e == ld_edge) begin
            LoadEn = 1'b1; LoadAddr = ld_a; LoadData = ld_d;
         end
         tick();
         LoadEn = 1'b0;
         if (e < lat && (use1 ? f1.InstReady : f4.InstReady)) early++;
      end
      if (ld && in_range(ld_a)) begin
         ref_mem[int'(ld_a[AW+1:2])] = ld_d;
         loaded_idx.push_back(int'(ld_a[AW+1:2]));
      end
      check({tag, "_early_rdy"}, 32'(early), 32'd0);
      check({tag, "_rdy"}, {31'd0, use1 ? f1.InstReady : f4.InstReady}, 32'd1);
      check({tag, "_data"}, use1 ? f1.InstfromRam : f4.InstfromRam, exp_d);
      check({tag, "_err"}, {31'd0, use1 ? f1.AddrErr : f4.AddrErr}, {31'd0, exp_e});
      for (int h = 0; h < hold; h++) begin
         tick();
         if (use1 ? f1.InstReady : f4.InstReady) extra++;
      end
      check({tag, "_busy_held"}, {31'd0, use1 ? busy1 : busy4}, 32'd1);
      f4.InstRead = 1'b0; f1.InstRead = 1'b0;
      tick();
      if (use1 ? f1.InstReady : f4.InstReady) extra++;
      check({tag, "_second_rdy"}, 32'(extra), 32'd0);
      check({tag, "_busy_release"}, {31'd0, use1 ? busy1 : busy4}, 32'd0);
      check({tag, "_data_kept"}, use1 ? f1.InstfromRam : f4.InstfromRam, exp_d);
   endtask

   initial begin
      int cnt;
      logic [31:0] a;
      logic [31:0] la;
      int idx;
      int lat_sel;
      f4.InstRead = 1'b0; f4.InstAddress = 32'd0;
      f1.InstRead = 1'b0; f1.InstAddress = 32'd0;
      #12;
      check("rst_rdy", {31'd0, f4.InstReady}, 32'd0);
      check("rst_data", f4.InstfromRam, 32'd0);
      check("rst_busy", {31'd0, busy4}, 32'd0);
      check("rst_err", {31'd0, f4.AddrErr}, 32'd0);
      nReset = 1'b1;
      tick();

      load(32'h0, 32'h0050_0093);
      load(32'h4, 32'h0010_0113);
      load(32'h8, 32'h0020_81B3);
      load(32'hC, 32'h0000_0013);

      req("rd8", 1'b0, 32'h8, 3, 1'b0, 0, 32'h0, 32'h0);
      req("rd4", 1'b0, 32'h4, 1, 1'b0, 0, 32'h0, 32'h0);

      // Abort after two WAIT cycles: no response, back to IDLE.
      f4.InstAddress = 32'h10; f4.InstRead = 1'b1;
      tick(); tick(); tick();
      f4.InstRead = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (f4.InstReady) cnt++;
      end
      check("abort_rdy", 32'(cnt), 32'd0);
      check("abort_busy", {31'd0, busy4}, 32'd0);
      req("after_abort", 1'b0, 32'h0, 1, 1'b0, 0, 32'h0, 32'h0);

      req("oor", 1'b0, 32'h0001_0000, 1, 1'b0, 0, 32'h0, 32'h0);
      req("mis", 1'b0, 32'h6, 2, 1'b0, 0, 32'h0, 32'h0);

      // Out-of-range load aliasing word 1 must be dropped.
      load(32'h0001_0004, 32'hBAD0_BAD0);
      req("oor_load", 1'b0, 32'h4, 1, 1'b0, 0, 32'h0, 32'h0);

      // Asynchronous reset in WAIT.
      f4.InstAddress = 32'h0; f4.InstRead = 1'b1;
      tick(); tick(); tick();
      #2 nReset = 1'b0;
      #1;
      check("arst_rdy", {31'd0, f4.InstReady}, 32'd0);
      check("arst_busy", {31'd0, busy4}, 32'd0);
      check("arst_data", f4.InstfromRam, 32'd0);
      f4.InstRead = 1'b0;
      #2 nReset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (f4.InstReady) cnt++;
      end
      check("arst_no_rdy", 32'(cnt), 32'd0);
      req("arst_intact", 1'b0, 32'h0, 1, 1'b0, 0, 32'h0, 32'h0);

      // Load on the accept edge is seen at LATENCY=1; load on the read edge is not.
      req("lat1_ld", 1'b1, 32'hC, 1, 1'b1, 0, 32'hC, 32'hDEAD_BEEF);
      req("rbw", 1'b0, 32'h8, 1, 1'b1, 4, 32'h8, 32'h1234_5678);
      req("rbw_new", 1'b0, 32'h8, 1, 1'b0, 0, 32'h0, 32'h0);

      for (int i = 0; i < 12; i++) begin
         load({16'd0, 2'b00, 12'($urandom_range(0, 4095)), 2'b00}, $urandom);
      end
      for (int i = 0; i < 20; i++) begin
         idx = loaded_idx[$urandom_range(0, loaded_idx.size() - 1)];
         a = {16'd0, 14'(idx), 2'b00};
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 5) == 0) a[31:16] = 16'($urandom_range(1, 65535));
         la = ($urandom_range(0, 1) == 1) ? {a[31:2], 2'b00} : {18'd0, 12'($urandom), 2'b00};
         if ($urandom_range(0, 4) == 0) la[31] = 1'b1;
         lat_sel = int'($urandom_range(0, 1));
         req($sformatf("rnd%0d", i), lat_sel[0], a, int'($urandom_range(1, 3)),
             $urandom_range(0, 1) == 1, int'($urandom_range(0, lat_sel[0] ? 1 : 4)), la, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
